// File: rtl/inport_debouncer.sv
// inport_debouncer: conditions board switches/keys for a PIO inport.
// Each input is optionally inverted (active-low keys), synchronised with two
// flops, then debounced by requiring STABLE_TICKS consecutive sample ticks of
// disagreement before the clean level follows. Level changes raise a one-cycle
// pulse and per-bit sticky event flags that drive a registered interrupt.
`timescale 1ns/1ps

module inport_debouncer #(
    parameter int               WIDTH        = 16,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] INVERT_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             clear_events,
    output logic [WIDTH-1:0] debounced,
    output logic             change_pulse,
    output logic [WIDTH-1:0] events,
    output logic             irq
);

    // 20 bits covers the largest legal divider (count tops out at 2^20-1).
    localparam int            PW        = 20;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    CNT_LAST  = 4'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]      cond;
    logic [WIDTH-1:0]      sync1;
    logic [WIDTH-1:0]      sync2;
    logic [WIDTH-1:0]      state;
    logic [WIDTH-1:0]      toggled;
    logic [WIDTH-1:0][3:0] cnt;
    logic [WIDTH-1:0][3:0] cnt_next;
    logic [PW-1:0]         presc;
    logic                  tick;

    // Active-low keys are flipped here so everything downstream is active-high.
    assign cond      = raw_in ^ INVERT_MASK;
    assign tick      = (presc == TICK_LAST);
    assign debounced = state;

    // Two-flop synchroniser for the asynchronous pin levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= cond;
            sync2 <= sync1;
        end
    end

    // Sample-tick prescaler counting 0..TICK_DIV-1 and wrapping on the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Per-bit stability counting: agreement clears the count at once, each
    // disagreeing tick advances it, and the last one accepts the new level.
    always_comb begin
        toggled  = '0;
        cnt_next = cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == state[i]) begin
                cnt_next[i] = 4'd0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    toggled[i]  = 1'b1;
                    cnt_next[i] = 4'd0;
                end else begin
                    cnt_next[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    // Debounced state and stability counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            cnt   <= '0;
        end else begin
            state <= state ^ toggled;
            cnt   <= cnt_next;
        end
    end

    // Change pulse, sticky events (a toggle wins over a simultaneous clear)
    // and the interrupt, which trails the event flags by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            change_pulse <= 1'b0;
            events       <= '0;
            irq          <= 1'b0;
        end else begin
            change_pulse <= |toggled;
            events       <= (clear_events ? '0 : events) | toggled;
            irq          <= |events;
        end
    end

endmodule

// File: tb/tb_inport_debouncer.sv
// tb_inport_debouncer: three debouncer instances (fast divider, inverted low
// nibble, divide-by-3) share one stimulus stream. A reference model predicts
// every cycle's outputs into a scoreboard queue; a monitor pops and compares.
`timescale 1ns/1ps

module tb_inport_debouncer;

    localparam int W  = 16;
    localparam int ST = 4;
    localparam int ND = 3;

    typedef struct packed {
        logic [ND-1:0][W-1:0] deb;
        logic [ND-1:0]        pulse;
        logic [ND-1:0][W-1:0] ev;
        logic [ND-1:0]        irq;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic         clear_events;

    logic [W-1:0] deb_a, deb_b, deb_c, ev_a, ev_b, ev_c;
    logic         pulse_a, pulse_b, pulse_c, irq_a, irq_b, irq_c;

    logic [ND-1:0][W-1:0] deb_o;
    logic [ND-1:0][W-1:0] ev_o;
    logic [ND-1:0]        pulse_o;
    logic [ND-1:0]        irq_o;

    assign deb_o   = {deb_c, deb_b, deb_a};
    assign ev_o    = {ev_c, ev_b, ev_a};
    assign pulse_o = {pulse_c, pulse_b, pulse_a};
    assign irq_o   = {irq_c, irq_b, irq_a};

    exp_t exp_q[$];
    int   check_count = 0;
    int   fail_count  = 0;

    // Reference model state: accepted levels, sticky events, and for every bit
    // the edge at which its current run of disagreement began.
    logic [W-1:0] m_level   [ND];
    logic [W-1:0] m_events  [ND];
    logic [W-1:0] run_active[ND];
    int           run_start [ND][W];
    logic [W-1:0] raw_hist[$];
    int           edge_no;

    inport_debouncer #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(ST), .INVERT_MASK(16'h0000)) dut_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clear_events(clear_events),
        .debounced(deb_a), .change_pulse(pulse_a), .events(ev_a), .irq(irq_a));

    inport_debouncer #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(ST), .INVERT_MASK(16'h000F)) dut_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clear_events(clear_events),
        .debounced(deb_b), .change_pulse(pulse_b), .events(ev_b), .irq(irq_b));

    inport_debouncer #(.WIDTH(W), .TICK_DIV(3), .STABLE_TICKS(ST), .INVERT_MASK(16'h0000)) dut_c (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clear_events(clear_events),
        .debounced(deb_c), .change_pulse(pulse_c), .events(ev_c), .irq(irq_c));

    always #5 clk = ~clk;

    function automatic int div_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic logic [W-1:0] mask_of(input int d);
        return (d == 1) ? 16'h000F : 16'h0000;
    endfunction

    // Number of sample ticks among edges s..k inclusive (tick when (edge+1) % div == 0).
    function automatic int ticks_in(input int s, input int k, input int div);
        return (k + 1) / div - s / div;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Predict the outputs after the coming rising edge and queue them.
    task automatic modelEdge(input logic [W-1:0] raw, input logic clr, input logic rstn);
        exp_t e;
        e = '0;
        if (!rstn) begin
            for (int d = 0; d < ND; d++) begin
                m_level[d]    = '0;
                m_events[d]   = '0;
                run_active[d] = '0;
            end
            raw_hist.delete();
            edge_no = 0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                int           div;
                logic         tick;
                logic [W-1:0] seen;
                logic [W-1:0] toggled;
                div     = div_of(d);
                tick    = ((edge_no % div) == div - 1);
                seen    = (edge_no >= 2) ? (raw_hist[edge_no - 2] ^ mask_of(d)) : '0;
                toggled = '0;
                e.irq[d] = |m_events[d];
                for (int i = 0; i < W; i++) begin
                    if (seen[i] == m_level[d][i]) begin
                        run_active[d][i] = 1'b0;
                    end else begin
                        if (!run_active[d][i]) begin
                            run_active[d][i] = 1'b1;
                            run_start[d][i]  = edge_no;
                        end
                        if (tick && ticks_in(run_start[d][i], edge_no, div) == ST) begin
                            toggled[i]       = 1'b1;
                            run_active[d][i] = 1'b0;
                        end
                    end
                end
                m_level[d]  = m_level[d] ^ toggled;
                m_events[d] = (clr ? '0 : m_events[d]) | toggled;
                e.deb[d]    = m_level[d];
                e.pulse[d]  = |toggled;
                e.ev[d]     = m_events[d];
            end
            raw_hist.push_back(raw);
            edge_no++;
        end
        exp_q.push_back(e);
    endtask

    // Drive inputs on the falling edge for n cycles, queuing a prediction per cycle.
    task automatic applyStimulus(input logic [W-1:0] raw, input logic clr, input logic rstn, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            raw_in       = raw;
            clear_events = clr;
            reset_n      = rstn;
            modelEdge(raw, clr, rstn);
        end
    endtask

    // Monitor: just after each rising edge, compare every instance with the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < ND; d++) begin
                    checkOutput($sformatf("dut%0d debounced", d), 32'(deb_o[d]), 32'(e.deb[d]));
                    checkOutput($sformatf("dut%0d change_pulse", d), 32'(pulse_o[d]), 32'(e.pulse[d]));
                    checkOutput($sformatf("dut%0d events", d), 32'(ev_o[d]), 32'(e.ev[d]));
                    checkOutput($sformatf("dut%0d irq", d), 32'(irq_o[d]), 32'(e.irq[d]));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] cur;
        reset_n      = 1'b0;
        raw_in       = '0;
        clear_events = 1'b0;

        // Reset held with all pins high: every output stays quiet.
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 3);
        checkOutput("reset debounced", 32'(deb_a), 32'h0);
        checkOutput("reset events", 32'(ev_a), 32'h0);
        checkOutput("reset irq", 32'(irq_a), 32'h0);

        // Inverted keys held released from reset, then key 1 pressed.
        applyStimulus(16'h000F, 1'b0, 1'b0, 2);
        applyStimulus(16'h000F, 1'b0, 1'b1, 12);
        checkOutput("inverted idle debounced", 32'(deb_b), 32'h0);
        checkOutput("plain nibble debounced", 32'(deb_a), 32'h000F);
        applyStimulus(16'h000D, 1'b0, 1'b1, 5);
        checkOutput("inverted press before accept", 32'(deb_b), 32'h0);
        applyStimulus(16'h000D, 1'b0, 1'b1, 2);
        checkOutput("inverted press debounced", 32'(deb_b), 32'h0002);
        checkOutput("inverted press events", 32'(ev_b), 32'h0002);

        // Bit 3 bounces 3 high / 1 low and must never be accepted.
        applyStimulus(16'h0000, 1'b0, 1'b0, 2);
        applyStimulus(16'h0000, 1'b0, 1'b1, 6);
        for (int r = 0; r < 10; r++) begin
            applyStimulus(16'h0008, 1'b0, 1'b1, 3);
            applyStimulus(16'h0000, 1'b0, 1'b1, 1);
        end
        applyStimulus(16'h0000, 1'b0, 1'b1, 6);
        checkOutput("bounce debounced", 32'(deb_a), 32'h0);
        checkOutput("bounce events", 32'(ev_a), 32'h0);

        // Bit 0 rises and is held.
        applyStimulus(16'h0001, 1'b0, 1'b1, 8);
        checkOutput("bit0 debounced", 32'(deb_a), 32'h0001);
        checkOutput("bit0 events", 32'(ev_a), 32'h0001);
        checkOutput("bit0 irq", 32'(irq_a), 32'h1);

        // Bit 5 is accepted on the same edge that clear_events is high.
        applyStimulus(16'h0021, 1'b0, 1'b1, 5);
        applyStimulus(16'h0021, 1'b1, 1'b1, 1);
        applyStimulus(16'h0021, 1'b0, 1'b1, 2);
        checkOutput("clear race events", 32'(ev_a), 32'h0020);
        checkOutput("clear race irq", 32'(irq_a), 32'h1);
        checkOutput("clear race debounced", 32'(deb_a), 32'h0021);

        // Divide-by-3 instance: reset mid-count must discard the partial count.
        applyStimulus(16'h0000, 1'b0, 1'b0, 2);
        applyStimulus(16'h0000, 1'b0, 1'b1, 6);
        applyStimulus(16'h0004, 1'b0, 1'b1, 8);
        applyStimulus(16'h0004, 1'b0, 1'b0, 2);
        checkOutput("mid-count reset debounced", 32'(deb_c), 32'h0);
        checkOutput("mid-count reset events", 32'(ev_c), 32'h0);
        applyStimulus(16'h0004, 1'b0, 1'b1, 11);
        checkOutput("restart not yet accepted", 32'(deb_c), 32'h0);
        applyStimulus(16'h0004, 1'b0, 1'b1, 2);
        checkOutput("restart accepted", 32'(deb_c), 32'h0004);
        applyStimulus(16'h0004, 1'b0, 1'b1, 4);

        // Randomised pin activity with occasional clears and resets.
        cur = 16'h0004;
        for (int n = 0; n < 800; n++) begin
            logic [W-1:0] flip;
            logic         clr;
            logic         rstn;
            flip = W'($urandom & $urandom & $urandom & $urandom);
            clr  = ($urandom_range(0, 15) == 0);
            rstn = ($urandom_range(0, 299) != 0);
            cur  = cur ^ flip;
            applyStimulus(cur, clr, rstn, 1);
        end
        applyStimulus(cur, 1'b0, 1'b1, 10);

        @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/inport_debouncer.md
INPORT_DEBOUNCER -- requirements
Module: inport_debouncer

Interface
REQ-001 Parameter WIDTH, default 16: number of conditioned input bits (board switches/keys).
REQ-002 Parameter TICK_DIV, default 50000: clock cycles per sample tick (1 ms at 50 MHz), legal range 1..2^20.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive disagreeing ticks needed to accept a new level, legal range 1..15.
REQ-004 Parameter INVERT_MASK, default all zeros, WIDTH bits: bits set to 1 mark active-low inputs (push keys), which are inverted before synchronisation.
REQ-005 clk  input  1  single system clock; all state is on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 raw_in  input  WIDTH  asynchronous pin levels from switches/keys.
REQ-008 clear_events  input  1  synchronous one-cycle request to clear the sticky event flags.
REQ-009 debounced  output  WIDTH  registered clean levels; these feed the PIO inport external connection.
REQ-010 change_pulse  output  1  registered, high for one cycle when any debounced bit changes.
REQ-011 events  output  WIDTH  registered sticky per-bit change flags.
REQ-012 irq  output  1  registered; equals the OR of events, delayed one cycle.

Function
REQ-013 cond = raw_in XOR INVERT_MASK shall pass through a two-flop synchroniser (sync1, then sync2) per bit.
REQ-014 A prescaler shall count 0..TICK_DIV-1 and wrap; tick is high in the cycle where the count equals TICK_DIV-1, so TICK_DIV=1 gives a tick every cycle.
REQ-015 Each bit shall have a 4-bit stability counter cnt[i] and a state bit state[i]; debounced equals state.
REQ-016 In any cycle where sync2[i]==state[i], cnt[i] shall return to 0, whether or not tick is high.
REQ-017 At a tick where sync2[i]!=state[i] and cnt[i]<STABLE_TICKS-1, cnt[i] shall increment.
REQ-018 At a tick where sync2[i]!=state[i] and cnt[i]==STABLE_TICKS-1, state[i] shall flip and cnt[i] shall return to 0.
REQ-019 Latency with TICK_DIV=1: if raw_in is first sampled at its new level at edge E and stays stable, debounced updates at edge E+1+STABLE_TICKS.
REQ-020 A glitch that returns sync2 to state before acceptance shall restart the count; no change is emitted.
REQ-021 toggled = bits flipping at the current edge; change_pulse shall be registered as OR(toggled) at the same edge.
REQ-022 The next value of events shall be (clear_events ? 0 : events) OR toggled, so a toggle coinciding with clear_events stays set.
REQ-023 Multiple bits may flip at the same edge; every flipping bit shall set its own events bit.
REQ-024 Changes from the reset value of debounced are real events and shall set events after reset.

Reset
REQ-025 While reset_n is low, sync1, sync2, state, cnt, the prescaler, change_pulse, events and irq shall all be 0, so debounced=0.
REQ-026 Reset asserted mid-count shall abort the count; after release, counting shall restart from 0 with no residual state.
REQ-027 Reset deassertion is synchronised externally; the block has no internal reset synchroniser.

Verification (WIDTH=16, TICK_DIV=1, STABLE_TICKS=4, INVERT_MASK=0 unless stated)
REQ-028 Reset, raw_in=0xFFFF held low for 3 cycles -> debounced=0, events=0, change_pulse=0, irq=0 throughout.
REQ-029 raw_in[0] goes 0->1 and is held, first sampled at edge E -> debounced=0x0001 at edge E+5, change_pulse high for exactly one cycle, events=0x0001, irq=1 one cycle later.
REQ-030 raw_in[3] bounces 3 cycles high, 1 cycle low, repeated 10 times -> debounced[3]=0, events=0, change_pulse never high.
REQ-031 events=0x0001, then bit5 flips at the same edge as clear_events=1 -> events=0x0020, irq stays 1.
REQ-032 INVERT_MASK=0x000F, raw_in=0x000F from reset, then raw_in[1] driven low -> debounced stays 0 until 0x0002 appears 5 edges after sampling; events=0x0002.
REQ-033 TICK_DIV=3, bit2 held changed, reset pulsed low after 2 ticks -> all outputs 0; after release, acceptance takes a full 4 ticks plus synchroniser delay.
